// File: rtl/imem_loader_if.sv
// Bundle of the loader's byte-stream input, instruction-memory write port and status flags.
// The loader side is the master because it drives the memory write bus.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              busy;
    logic              cpu_run;
    logic              err;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, words_loaded, busy, cpu_run, err
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, words_loaded, busy, cpu_run, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes little-endian words into instruction
// memory from address 0 and releases the core (cpu_run) only after the XOR checksum matches.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [7:0]        lenLo_q, lenLo_d;
    logic [ADDR_W:0]   nWords_q, nWords_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       partial_q, partial_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic            busy;
    logic            xfer;
    logic [16:0]     lenFull;
    logic [ADDR_W:0] countInc;

    assign busy     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer     = busy && bus.in_valid;
    assign lenFull  = {1'b0, bus.in_data, lenLo_q};
    assign countInc = count_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        lenLo_d   = lenLo_q;
        nWords_d  = nWords_q;
        lane_d    = lane_q;
        partial_d = partial_q;
        xor_d     = xor_q;
        count_d   = count_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LEN_LO;
                    count_d = '0;
                    lane_d  = '0;
                    xor_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    lenLo_d = bus.in_data;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (lenFull != 17'd0 && lenFull <= CAPACITY) begin
                        nWords_d = lenFull[ADDR_W:0];
                        state_d  = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    xor_d  = xor_q ^ bus.in_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q != 2'd3) begin
                        partial_d[{lane_q, 3'b000} +: 8] = bus.in_data;
                    end else begin
                        // Lane 3 completes the word: write it at the pre-increment count.
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = {bus.in_data, partial_q};
                        count_d = countInc;
                        if (countInc == nWords_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == xor_q) ? S_RUN : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lenLo_q   <= '0;
            nWords_q  <= '0;
            lane_q    <= '0;
            partial_q <= '0;
            xor_q     <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lenLo_q   <= lenLo_d;
            nWords_q  <= nWords_d;
            lane_q    <= lane_d;
            partial_q <= partial_d;
            xor_q     <= xor_d;
            count_q   <= count_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.in_ready     = busy;
    assign bus.busy         = busy;
    assign bus.cpu_run      = (state_q == S_RUN);
    assign bus.err          = (state_q == S_ERR);
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.words_loaded = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Drives one byte stream into two loaders (ADDR_W=8 and ADDR_W=2) and checks their memory
// writes and final status against the expected result derived from the stream contents.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       inValid = 1'b0;
    logic [7:0] inData = 8'h00;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] words [4];
    logic [47:0] monA[$];
    logic [47:0] monB[$];

    imem_loader_if #(.ADDR_W(8)) ifA ();
    imem_loader_if #(.ADDR_W(2)) ifB ();

    assign ifA.start    = start;
    assign ifA.in_valid = inValid;
    assign ifA.in_data  = inData;
    assign ifB.start    = start;
    assign ifB.in_valid = inValid;
    assign ifB.in_data  = inData;

    imem_loader #(.ADDR_W(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    imem_loader #(.ADDR_W(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifA.imem_we) monA.push_back({16'(ifA.imem_addr), ifA.imem_wdata});
        if (ifB.imem_we) monB.push_back({16'(ifB.imem_addr), ifB.imem_wdata});
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap, input bit noisy);
        inValid = 1'b1;
        inData  = b;
        tick();
        inValid = 1'b0;
        repeat (gap) begin
            if (noisy && $urandom_range(0, 1) == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " A"}, {ifA.in_ready, ifA.imem_we, ifA.busy, ifA.cpu_run, ifA.err,
                                  ifA.words_loaded, ifA.imem_addr, ifA.imem_wdata}, 64'd0);
        checkOutput({tag, " B"}, {ifB.in_ready, ifB.imem_we, ifB.busy, ifB.cpu_run, ifB.err,
                                  ifB.words_loaded, ifB.imem_addr, ifB.imem_wdata}, 64'd0);
    endtask

    // Full load of words[0..n-1]; the expected outcome follows directly from the stream contents.
    task automatic applyStimulus(input int n, input bit corrupt, input int gap, input bit noisy);
        logic [7:0] csum;
        logic [7:0] sentSum;
        bit good;
        monA.delete();
        monB.delete();
        pulseStart();
        checkOutput("start busy A/B", {ifA.busy, ifB.busy, ifA.in_ready, ifA.err, ifB.err}, 5'b11100);
        checkOutput("start count", {ifA.words_loaded, ifB.words_loaded}, 12'd0);
        csum = 8'h00;
        for (int i = 0; i < n; i++) csum ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        sentSum = corrupt ? (csum ^ 8'h01) : csum;
        good = !corrupt;
        sendByte(8'(n), gap, noisy);
        sendByte(8'(n >> 8), gap, noisy);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) sendByte(words[i][8*k +: 8], gap, noisy);
        sendByte(sentSum, 0, 1'b0);
        checkOutput("writes A", 64'(monA.size()), 64'(n));
        checkOutput("writes B", 64'(monB.size()), 64'(n));
        for (int i = 0; i < n && i < monA.size(); i++)
            checkOutput($sformatf("wr A%0d", i), 64'(monA[i]), 64'({16'(i), words[i]}));
        for (int i = 0; i < n && i < monB.size(); i++)
            checkOutput($sformatf("wr B%0d", i), 64'(monB[i]), 64'({16'(i), words[i]}));
        checkOutput("count A", 64'(ifA.words_loaded), 64'(n));
        checkOutput("count B", 64'(ifB.words_loaded), 64'(n));
        checkOutput("status A", {ifA.cpu_run, ifA.err, ifA.in_ready}, {good, !good, 1'b0});
        checkOutput("status B", {ifB.cpu_run, ifB.err, ifB.in_ready}, {good, !good, 1'b0});
    endtask

    task automatic illegalLength(input logic [7:0] lo, input logic [7:0] hi);
        monA.delete();
        monB.delete();
        pulseStart();
        sendByte(lo, 0, 1'b0);
        sendByte(hi, 0, 1'b0);
        checkOutput("badlen status", {ifA.err, ifB.err, ifA.in_ready, ifB.in_ready, ifA.cpu_run}, 5'b11000);
        repeat (2) tick();
        checkOutput("badlen writes", 64'(monA.size() + monB.size()), 64'd0);
    endtask

    initial begin
        #22;
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        words[0] = 32'h00500093;
        words[1] = 32'h00100113;
        applyStimulus(2, 1'b0, 0, 1'b0);
        applyStimulus(2, 1'b1, 0, 1'b0);

        illegalLength(8'h00, 8'h00);
        illegalLength(8'h01, 8'h01);

        applyStimulus(2, 1'b0, 3, 1'b1);

        pulseStart();
        sendByte(8'h02, 0, 1'b0);
        sendByte(8'h00, 0, 1'b0);
        for (int k = 0; k < 5; k++) sendByte(words[k / 4][8*(k % 4) +: 8], 0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkReset("midload reset");
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(2, 1'b0, 0, 1'b0);

        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;
        applyStimulus(4, 1'b0, 0, 1'b0);
        checkOutput("full addr B", 64'(monB.size() == 4 ? monB[3][33:32] : 2'b00), 64'd3);
        pulseStart();
        checkOutput("rerun B", {ifB.cpu_run, ifB.busy, ifB.words_loaded}, {1'b0, 1'b1, 3'd0});

        sendByte(8'h05, 0, 1'b0);
        sendByte(8'h00, 0, 1'b0);
        checkOutput("N=5 A/B", {ifA.busy, ifA.err, ifB.busy, ifB.err}, 4'b1001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) words[i] = $urandom;
            applyStimulus(n, $urandom_range(0, 3) == 0, $urandom_range(0, 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
